// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: result-select load code,
// forwarding-select codes, architectural zero register and FSM states.
package hazard_ctrl_pkg;

    localparam logic [1:0] RES_LOAD = 2'b01;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR  = 2'b10
    } hz_state_t;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Forward-select for one E-stage source operand. The M stage holds the
// younger producer, so it is checked before W; x0 is never forwarded.
module hazard_fwd_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output logic [1:0] fwd
);

    // Priority select: M result, then W result, then register file
    always_comb begin
        fwd = FWD_RF;
        if (reg_write_m && (rd_m != REG_X0) && (rd_m == rs)) begin
            fwd = FWD_M;
        end else if (reg_write_w && (rd_w != REG_X0) && (rd_w == rs)) begin
            fwd = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard controller for the 5-stage pipeline: stall/flush control,
// E-stage forwarding selects, data-memory wait sequencing with a watchdog,
// and saturating performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic [4:0]       rd_m,
    input  logic [4:0]       rd_w,
    input  logic             reg_write_m,
    input  logic             reg_write_w,
    input  logic [1:0]       result_src_e,
    input  logic             pc_src_e,
    input  logic             mem_req_m,
    input  logic             mem_ready,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_w,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic             mem_err,
    output logic [CNT_W-1:0] cnt_lu,
    output logic [CNT_W-1:0] cnt_flush,
    output logic [CNT_W-1:0] cnt_mwait
);

    localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    hz_state_t         state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
    logic              lu;
    logic              freeze;

    hazard_fwd_unit u_fwd_a (
        .rs          (rs1_e),
        .rd_m        (rd_m),
        .rd_w        (rd_w),
        .reg_write_m (reg_write_m),
        .reg_write_w (reg_write_w),
        .fwd         (forward_a_e)
    );

    hazard_fwd_unit u_fwd_b (
        .rs          (rs2_e),
        .rd_m        (rd_m),
        .rd_w        (rd_w),
        .reg_write_m (reg_write_m),
        .reg_write_w (reg_write_w),
        .fwd         (forward_b_e)
    );

    // Load in E whose destination is read by the instruction in D
    always_comb begin
        lu = (result_src_e == RES_LOAD) && (rd_e != REG_X0) &&
             ((rd_e == rs1_d) || (rd_e == rs2_d));
    end

    // Memory-wait FSM state and wait counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Next state: enter WAIT on an unready access, trip ERR once the
    // wait has lasted TIMEOUT consecutive cycles
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            ST_RUN: begin
                if (mem_req_m && !mem_ready) begin
                    state_next    = ST_WAIT;
                    wait_cnt_next = WAIT_ONE;
                end
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    state_next    = ST_RUN;
                    wait_cnt_next = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = ST_ERR;
                end else begin
                    wait_cnt_next = wait_cnt + WAIT_ONE;
                end
            end
            ST_ERR: begin
                state_next = ST_ERR;
            end
            default: begin
                state_next    = ST_RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    // Pipeline control: a memory freeze holds every stage and bubbles W;
    // otherwise a taken branch kills D/E and beats a load-use stall
    always_comb begin
        freeze  = ((state == ST_RUN) && mem_req_m && !mem_ready) ||
                  ((state == ST_WAIT) && !mem_ready) ||
                  (state == ST_ERR);
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_w = 1'b0;
        mem_err = (state == ST_ERR);
        if (freeze) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else begin
            flush_d = pc_src_e;
            flush_e = lu || pc_src_e;
            stall_f = lu && !pc_src_e;
            stall_d = lu && !pc_src_e;
        end
    end

    // Saturating performance counters, frozen once the watchdog has fired
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_lu    <= '0;
            cnt_flush <= '0;
            cnt_mwait <= '0;
        end else if (state != ST_ERR) begin
            if (lu && !freeze && !pc_src_e && (cnt_lu != CNT_MAX)) begin
                cnt_lu <= cnt_lu + CNT_ONE;
            end
            if (pc_src_e && !freeze && (cnt_flush != CNT_MAX)) begin
                cnt_flush <= cnt_flush + CNT_ONE;
            end
            if (freeze && (cnt_mwait != CNT_MAX)) begin
                cnt_mwait <= cnt_mwait + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios plus a randomized run
// against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [4:0]    rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic          reg_write_m, reg_write_w;
    logic [1:0]    result_src_e;
    logic          pc_src_e, mem_req_m, mem_ready;
    logic          stall_f, stall_d, flush_d, flush_e, stall_e, stall_m, flush_w;
    logic [1:0]    forward_a_e, forward_b_e;
    logic          mem_err;
    logic [CW-1:0] cnt_lu, cnt_flush, cnt_mwait;

    logic [6:0]    pipe;
    logic [11:0]   ctl;
    logic [3*CW-1:0] cnts;

    assign pipe = {stall_f, stall_d, flush_d, flush_e, stall_e, stall_m, flush_w};
    assign ctl  = {pipe, forward_a_e, forward_b_e, mem_err};
    assign cnts = {cnt_lu, cnt_flush, cnt_mwait};

    localparam logic [6:0] P_FREEZE = 7'b1100111;

    int total  = 0;
    int passed = 0;

    // Behavioural model state
    int   m_waits;
    bit   m_err;
    int   m_lu, m_fl, m_mw;
    bit   m_frz, m_luc, m_pc;
    logic [11:0]     exp_ctl;
    logic [3*CW-1:0] exp_cnt;

    hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .rs1_d        (rs1_d),
        .rs2_d        (rs2_d),
        .rs1_e        (rs1_e),
        .rs2_e        (rs2_e),
        .rd_e         (rd_e),
        .rd_m         (rd_m),
        .rd_w         (rd_w),
        .reg_write_m  (reg_write_m),
        .reg_write_w  (reg_write_w),
        .result_src_e (result_src_e),
        .pc_src_e     (pc_src_e),
        .mem_req_m    (mem_req_m),
        .mem_ready    (mem_ready),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_d      (flush_d),
        .flush_e      (flush_e),
        .stall_e      (stall_e),
        .stall_m      (stall_m),
        .flush_w      (flush_w),
        .forward_a_e  (forward_a_e),
        .forward_b_e  (forward_b_e),
        .mem_err      (mem_err),
        .cnt_lu       (cnt_lu),
        .cnt_flush    (cnt_flush),
        .cnt_mwait    (cnt_mwait)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
        if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_waits = 0;
        m_err   = 0;
        m_lu    = 0;
        m_fl    = 0;
        m_mw    = 0;
        exp_cnt = '0;
    endtask

    // Expected combinational outputs from current inputs and model state
    task automatic model_eval();
        logic [6:0] p;
        m_pc  = pc_src_e;
        m_luc = (result_src_e == 2'b01) && (rd_e != 0) &&
                ((rd_e == rs1_d) || (rd_e == rs2_d));
        m_frz = m_err || (!mem_ready && (m_waits > 0 || mem_req_m));
        if (m_frz) p = P_FREEZE;
        else p = {m_luc && !m_pc, m_luc && !m_pc, m_pc, m_luc || m_pc, 3'b000};
        exp_ctl = {p, ref_fwd(rs1_e), ref_fwd(rs2_e), m_err};
    endtask

    // Advance model across one clock edge
    task automatic model_clock();
        if (!m_err) begin
            if (m_luc && !m_frz && !m_pc && m_lu < MAXC) m_lu++;
            if (m_pc && !m_frz && m_fl < MAXC) m_fl++;
            if (m_frz && m_mw < MAXC) m_mw++;
            if (m_frz) begin
                m_waits++;
                if (m_waits >= TO) m_err = 1;
            end else begin
                m_waits = 0;
            end
        end
        exp_cnt = {CW'(m_lu), CW'(m_fl), CW'(m_mw)};
    endtask

    task automatic idle_inputs();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0;
        rd_e = 0; rd_m = 0; rd_w = 0;
        reg_write_m = 0; reg_write_w = 0;
        result_src_e = 2'b00; pc_src_e = 0;
        mem_req_m = 0; mem_ready = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        idle_inputs();
        model_reset();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (ctl !== 12'h000) $display("FAIL reset_ctl: got %b expected %b", ctl, 12'h000);
        else passed++;
        total++;
        if (cnts !== '0) $display("FAIL reset_cnt: got %h expected %h", cnts, 12'h000);
        else passed++;
        mem_req_m = 1; mem_ready = 0;
        #1;
        total++;
        if (pipe !== P_FREEZE) $display("FAIL reset_comb_freeze: got %b expected %b", pipe, P_FREEZE);
        else passed++;
        tick();
        total++;
        if (cnts !== '0) $display("FAIL reset_cnt_held: got %h expected %h", cnts, 12'h000);
        else passed++;
        apply_reset();
    endtask

    task automatic test_forwarding();
        apply_reset();
        rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1; rs1_e = 5;
        @(negedge clk);
        total++;
        if (forward_a_e !== 2'b10) $display("FAIL fwd_m_wins: got %b expected 10", forward_a_e);
        else passed++;
        tick();
        reg_write_m = 0;
        @(negedge clk);
        total++;
        if (forward_a_e !== 2'b01) $display("FAIL fwd_w: got %b expected 01", forward_a_e);
        else passed++;
        tick();
        reg_write_m = 1; rd_m = 0; rd_w = 0; rs1_e = 0;
        @(negedge clk);
        total++;
        if (forward_a_e !== 2'b00) $display("FAIL fwd_x0: got %b expected 00", forward_a_e);
        else passed++;
        tick();
        rs2_e = 9; rd_w = 9; rd_m = 3;
        @(negedge clk);
        total++;
        if ({forward_a_e, forward_b_e} !== 4'b0001) $display("FAIL fwd_b_w: got %b expected 0001", {forward_a_e, forward_b_e});
        else passed++;
        tick();
    endtask

    task automatic test_load_use();
        apply_reset();
        result_src_e = 2'b01; rd_e = 7; rs2_d = 7; rs1_d = 3; pc_src_e = 0;
        @(negedge clk);
        total++;
        if (pipe !== 7'b1101000) $display("FAIL lu_ctrl: got %b expected %b", pipe, 7'b1101000);
        else passed++;
        tick();
        idle_inputs();
        total++;
        if ({cnt_lu, cnt_flush} !== {4'd1, 4'd0}) $display("FAIL lu_cnt: got %h expected 10", {cnt_lu, cnt_flush});
        else passed++;
    endtask

    task automatic test_branch_beats_lu();
        apply_reset();
        result_src_e = 2'b01; rd_e = 7; rs2_d = 7; pc_src_e = 1;
        @(negedge clk);
        total++;
        if (pipe !== 7'b0011000) $display("FAIL br_lu_ctrl: got %b expected %b", pipe, 7'b0011000);
        else passed++;
        tick();
        idle_inputs();
        total++;
        if ({cnt_lu, cnt_flush} !== {4'd0, 4'd1}) $display("FAIL br_lu_cnt: got %h expected 01", {cnt_lu, cnt_flush});
        else passed++;
    endtask

    task automatic test_mem_wait();
        apply_reset();
        mem_req_m = 1; mem_ready = 0; pc_src_e = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (pipe !== P_FREEZE) $display("FAIL mwait_freeze %0d: got %b expected %b", k, pipe, P_FREEZE);
            else passed++;
            tick();
        end
        mem_ready = 1;
        @(negedge clk);
        total++;
        if (pipe !== 7'b0011000) $display("FAIL mwait_release: got %b expected %b", pipe, 7'b0011000);
        else passed++;
        tick();
        idle_inputs();
        total++;
        if ({cnt_flush, cnt_mwait, mem_err} !== {4'd1, 4'd3, 1'b0}) $display("FAIL mwait_cnt: got %h expected %h", {cnt_flush, cnt_mwait, mem_err}, {4'd1, 4'd3, 1'b0});
        else passed++;
    endtask

    task automatic test_timeout();
        apply_reset();
        mem_req_m = 1; mem_ready = 0;
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            total++;
            if ({pipe, mem_err} !== {P_FREEZE, 1'b0}) $display("FAIL to_wait %0d: got %b expected %b", k, {pipe, mem_err}, {P_FREEZE, 1'b0});
            else passed++;
            tick();
        end
        mem_req_m = 0; mem_ready = 1; pc_src_e = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if ({pipe, mem_err} !== {P_FREEZE, 1'b1}) $display("FAIL to_err %0d: got %b expected %b", k, {pipe, mem_err}, {P_FREEZE, 1'b1});
            else passed++;
            tick();
        end
        total++;
        if ({cnt_flush, cnt_mwait} !== {4'd0, 4'd4}) $display("FAIL to_cnt: got %h expected 04", {cnt_flush, cnt_mwait});
        else passed++;
        idle_inputs();
        rst = 1'b0;
        #1;
        total++;
        if ({pipe, mem_err} !== 8'h00) $display("FAIL to_reset: got %b expected 00000000", {pipe, mem_err});
        else passed++;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        mem_req_m = 1; mem_ready = 0;
        tick();
        mem_req_m = 0;
        @(negedge clk);
        total++;
        if (pipe !== P_FREEZE) $display("FAIL midw_wait: got %b expected %b", pipe, P_FREEZE);
        else passed++;
        #1;
        rst = 1'b0;
        #1;
        total++;
        if ({pipe, cnt_mwait} !== {7'b0, 4'd0}) $display("FAIL midw_reset: got %h expected 0", {pipe, cnt_mwait});
        else passed++;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_saturation();
        apply_reset();
        result_src_e = 2'b01; rd_e = 4; rs1_d = 4;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k == 14) begin
                total++;
                if (cnt_lu !== 4'hF) $display("FAIL sat_reach: got %h expected f", cnt_lu);
                else passed++;
            end
        end
        total++;
        if (cnt_lu !== 4'hF) $display("FAIL sat_hold: got %h expected f", cnt_lu);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 149) begin
                apply_reset();
            end else begin
                rs1_d = 5'($urandom_range(0, 3));
                rs2_d = 5'($urandom_range(0, 3));
                rs1_e = 5'($urandom_range(0, 3));
                rs2_e = 5'($urandom_range(0, 3));
                rd_e  = 5'($urandom_range(0, 3));
                rd_m  = 5'($urandom_range(0, 3));
                rd_w  = 5'($urandom_range(0, 3));
                reg_write_m  = 1'($urandom_range(0, 1));
                reg_write_w  = 1'($urandom_range(0, 1));
                result_src_e = 2'($urandom_range(0, 3));
                pc_src_e     = ($urandom_range(0, 4) == 0);
                mem_req_m    = 1'($urandom_range(0, 1));
                mem_ready    = ($urandom_range(0, 3) != 0);
                model_eval();
                @(negedge clk);
                total++;
                if (ctl !== exp_ctl) $display("FAIL rand_ctl %0d: got %b expected %b", i, ctl, exp_ctl);
                else passed++;
                @(posedge clk);
                model_clock();
                #1;
                total++;
                if (cnts !== exp_cnt) $display("FAIL rand_cnt %0d: got %h expected %h", i, cnts, exp_cnt);
                else passed++;
            end
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_beats_lu();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
